// File: rtl/serial_comparator_framed.sv
// Framed serial magnitude comparator.
// Operands arrive DIGIT_W bits per beat, framed by first/last markers.
// Bit order and signedness are chosen per frame on the first beat.
// One registered result is produced per frame, together with its beat count.
// Protocol errors and beat-count overflow are reported as a one-cycle err pulse.
module serial_comparator_framed #(
  parameter  int DIGIT_W   = 1,
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic               msb_first,
  input  logic               is_signed,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               res_valid,
  output logic               res_lt,
  output logic               res_eq,
  output logic               res_gt,
  output logic [CNT_W-1:0]   res_beats,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, EQUAL, LESS, GREATER} state_t;

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_BEATS);

  state_t             state, state_n;
  state_t             dcmp, base, rel;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W:0]     beat_cnt;
  logic               msb_mode, sgn_mode, msb_n, sgn_n;
  logic               cur_msb, cur_sgn, sign_digit;
  logic [DIGIT_W-1:0] a_adj, b_adj;
  logic               fire, err_n;

  // Relation of this beat's digits and the running relation it produces.
  // The mode comes from the live inputs on a first beat, else from the latched copy.
  // In the sign digit the MSBs are flipped so an unsigned compare orders two's complement.
  always_comb begin
    cur_msb    = in_first ? msb_first : msb_mode;
    cur_sgn    = in_first ? is_signed : sgn_mode;
    sign_digit = cur_sgn & (cur_msb ? in_first : in_last);
    a_adj      = a;
    b_adj      = b;
    if (sign_digit) begin
      a_adj[DIGIT_W-1] = ~a[DIGIT_W-1];
      b_adj[DIGIT_W-1] = ~b[DIGIT_W-1];
    end
    if (a_adj < b_adj)      dcmp = LESS;
    else if (a_adj > b_adj) dcmp = GREATER;
    else                    dcmp = EQUAL;
    base = in_first ? EQUAL : state;
    if (cur_msb) rel = (base == EQUAL) ? dcmp : base;
    else         rel = (dcmp != EQUAL) ? dcmp : base;
    beat_cnt = in_first ? (CNT_W+1)'(1) : ({1'b0, cnt} + (CNT_W+1)'(1));
  end

  // Frame control: start/restart, advance, finish, overflow abort and stray beats.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    msb_n   = msb_mode;
    sgn_n   = sgn_mode;
    fire    = 1'b0;
    err_n   = 1'b0;
    if (in_valid) begin
      if (in_first) begin
        err_n = (state != IDLE);
        msb_n = msb_first;
        sgn_n = is_signed;
        cnt_n = CNT_W'(1);
        if (in_last) begin
          fire    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          state_n = rel;
        end
      end else if (state == IDLE) begin
        err_n = 1'b1;
      end else if (beat_cnt > MAX_CNT) begin
        err_n   = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
      end else if (in_last) begin
        fire    = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n   = beat_cnt[CNT_W-1:0];
        state_n = rel;
      end
    end
  end

  // State, beat counter and latched frame mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      msb_mode <= 1'b0;
      sgn_mode <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      msb_mode <= msb_n;
      sgn_mode <= sgn_n;
    end
  end

  // Registered result pulse, held relation/beat count and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_lt    <= 1'b0;
      res_eq    <= 1'b0;
      res_gt    <= 1'b0;
      res_beats <= '0;
      err       <= 1'b0;
    end else begin
      res_valid <= fire;
      err       <= err_n;
      if (fire) begin
        res_lt    <= (rel == LESS);
        res_eq    <= (rel == EQUAL);
        res_gt    <= (rel == GREATER);
        res_beats <= beat_cnt[CNT_W-1:0];
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Directed bench for serial_comparator_framed.
// Three instances: 1-bit digits, 4-bit digits, and 1-bit digits with MAX_BEATS=4.
// sel routes in_valid to one instance and selects which outputs are observed.
module tb_serial_comparator_framed;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       in_valid, in_first, in_last, msb_first, is_signed;
  logic [3:0] a, b;
  int         total = 0;
  int         bad = 0;

  logic       rv0, lt0, eq0, gt0, busy0, err0;
  logic [4:0] beats0;
  logic       rv1, lt1, eq1, gt1, busy1, err1;
  logic [4:0] beats1;
  logic       rv2, lt2, eq2, gt2, busy2, err2;
  logic [2:0] beats2;

  logic       o_rv, o_busy, o_err;
  logic [2:0] o_rel;
  logic [7:0] o_beats;

  localparam logic [2:0] LT = 3'b100, EQ = 3'b010, GT = 3'b001, NONE = 3'b000;

  always #5 clk = ~clk;

  serial_comparator_framed #(.DIGIT_W(1), .MAX_BEATS(16)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd0), .in_first(in_first),
    .in_last(in_last), .msb_first(msb_first), .is_signed(is_signed),
    .a(a[0]), .b(b[0]), .res_valid(rv0), .res_lt(lt0), .res_eq(eq0), .res_gt(gt0),
    .res_beats(beats0), .busy(busy0), .err(err0));

  serial_comparator_framed #(.DIGIT_W(4), .MAX_BEATS(16)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd1), .in_first(in_first),
    .in_last(in_last), .msb_first(msb_first), .is_signed(is_signed),
    .a(a), .b(b), .res_valid(rv1), .res_lt(lt1), .res_eq(eq1), .res_gt(gt1),
    .res_beats(beats1), .busy(busy1), .err(err1));

  serial_comparator_framed #(.DIGIT_W(1), .MAX_BEATS(4)) dut_ov (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd2), .in_first(in_first),
    .in_last(in_last), .msb_first(msb_first), .is_signed(is_signed),
    .a(a[0]), .b(b[0]), .res_valid(rv2), .res_lt(lt2), .res_eq(eq2), .res_gt(gt2),
    .res_beats(beats2), .busy(busy2), .err(err2));

  // Route the selected instance's outputs to a common view.
  always_comb begin
    o_rv = rv0; o_rel = {lt0, eq0, gt0}; o_beats = {3'b0, beats0}; o_busy = busy0; o_err = err0;
    case (sel)
      2'd1: begin
        o_rv = rv1; o_rel = {lt1, eq1, gt1}; o_beats = {3'b0, beats1}; o_busy = busy1; o_err = err1;
      end
      2'd2: begin
        o_rv = rv2; o_rel = {lt2, eq2, gt2}; o_beats = {5'b0, beats2}; o_busy = busy2; o_err = err2;
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic l, input logic m, input logic s,
                               input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    in_valid = 1'b1; in_first = f; in_last = l; msb_first = m; is_signed = s; a = av; b = bv;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic expectResult(input string tag, input logic [2:0] rel, input int beats);
    checkOutput({tag, "_valid"}, 32'(o_rv), 32'd1);
    checkOutput({tag, "_rel"}, 32'(o_rel), 32'(rel));
    checkOutput({tag, "_beats"}, 32'(o_beats), 32'(beats));
  endtask

  logic [15:0] va, vb;

  initial begin
    rst = 1'b0; sel = 2'd0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    msb_first = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_rel", 32'(o_rel), 32'(NONE));
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_beats", 32'(o_beats), 32'd0);
    rst = 1'b1;

    // 16-beat MSB-first unsigned: 0x6482 > 0x6262
    va = 16'h6482; vb = 16'h6262;
    for (int i = 15; i >= 0; i--) begin
      if (i == 7) checkOutput("w1_busy_mid", 32'(o_busy), 32'd1);
      applyStimulus(i == 15, i == 0, 1'b1, 1'b0, {3'b0, va[i]}, {3'b0, vb[i]});
    end
    idleCycle();
    expectResult("w1_16beat", GT, 16);
    idleCycle();
    checkOutput("w1_rv_drop", 32'(o_rv), 32'd0);
    checkOutput("w1_busy_end", 32'(o_busy), 32'd0);

    // 4-bit digits, LSB-first unsigned
    sel = 2'd1;
    applyStimulus(1, 0, 0, 0, 4'h2, 4'h1);
    applyStimulus(0, 1, 0, 0, 4'h1, 4'h2);
    idleCycle();
    expectResult("w4_lsb_lt", LT, 2);
    applyStimulus(1, 0, 0, 0, 4'hA, 4'hA);
    applyStimulus(0, 1, 0, 0, 4'h5, 4'h5);
    idleCycle();
    expectResult("w4_lsb_eq", EQ, 2);

    // 4-bit digits, MSB-first signed vs unsigned, then LSB-first signed
    applyStimulus(1, 0, 1, 1, 4'hF, 4'h1);
    applyStimulus(0, 1, 1, 1, 4'h0, 4'h0);
    idleCycle();
    expectResult("w4_msb_sgn", LT, 2);
    applyStimulus(1, 0, 1, 0, 4'hF, 4'h1);
    applyStimulus(0, 1, 1, 0, 4'h0, 4'h0);
    idleCycle();
    expectResult("w4_msb_uns", GT, 2);
    applyStimulus(1, 0, 0, 1, 4'h0, 4'h0);
    applyStimulus(0, 1, 0, 1, 4'hF, 4'h1);
    idleCycle();
    expectResult("w4_lsb_sgn", LT, 2);

    // MAX_BEATS=4: legal frame of exactly 4 beats, then overflow with 5 unterminated beats
    sel = 2'd2;
    for (int i = 1; i <= 4; i++) applyStimulus(i == 1, i == 4, 1, 0, 4'(i == 3 ? 0 : 1), 4'h1);
    idleCycle();
    expectResult("ov_max_legal", LT, 4);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        checkOutput("ov_err_before", 32'(o_err), 32'd0);
        checkOutput("ov_busy_before", 32'(o_busy), 32'd1);
      end
      applyStimulus(i == 1, 1'b0, 1, 0, 4'h1, 4'h0);
    end
    idleCycle();
    checkOutput("ov_err", 32'(o_err), 32'd1);
    checkOutput("ov_busy", 32'(o_busy), 32'd0);
    checkOutput("ov_no_result", 32'(o_rv), 32'd0);
    checkOutput("ov_rel_held", 32'(o_rel), 32'(LT));
    checkOutput("ov_beats_held", 32'(o_beats), 32'd4);

    // Protocol: stray beat in IDLE, restart mid-frame, single-beat frame, back-to-back frames
    sel = 2'd0;
    applyStimulus(0, 0, 1, 0, 4'h1, 4'h0);
    idleCycle();
    checkOutput("stray_err", 32'(o_err), 32'd1);
    checkOutput("stray_busy", 32'(o_busy), 32'd0);
    applyStimulus(1, 0, 1, 0, 4'h0, 4'h1);
    applyStimulus(1, 0, 1, 0, 4'h1, 4'h0);
    idleCycle();
    checkOutput("restart_err", 32'(o_err), 32'd1);
    checkOutput("restart_busy", 32'(o_busy), 32'd1);
    checkOutput("restart_no_res", 32'(o_rv), 32'd0);
    applyStimulus(0, 1, 1, 0, 4'h0, 4'h0);
    idleCycle();
    expectResult("restart_res", GT, 2);
    checkOutput("restart_err_clr", 32'(o_err), 32'd0);
    applyStimulus(1, 1, 1, 0, 4'h1, 4'h0);
    idleCycle();
    expectResult("single_beat", GT, 1);
    applyStimulus(1, 1, 1, 0, 4'h0, 4'h1);
    applyStimulus(1, 1, 0, 0, 4'h1, 4'h0);
    expectResult("b2b_first", LT, 1);
    checkOutput("b2b_no_err", 32'(o_err), 32'd0);
    idleCycle();
    expectResult("b2b_second", GT, 1);

    // Asynchronous reset between clock edges in the middle of a frame
    applyStimulus(1, 0, 1, 0, 4'h1, 4'h1);
    applyStimulus(0, 0, 1, 0, 4'h0, 4'h0);
    idleCycle();
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(o_busy), 32'd0);
    checkOutput("arst_rel", 32'(o_rel), 32'(NONE));
    checkOutput("arst_beats", 32'(o_beats), 32'd0);
    checkOutput("arst_rv", 32'(o_rv), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 0, 1, 0, 4'h1, 4'h1);
    applyStimulus(0, 1, 1, 0, 4'h0, 4'h1);
    idleCycle();
    expectResult("post_rst", LT, 2);
    checkOutput("post_rst_err", 32'(o_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_comparator_framed.md
Name: serial_comparator_framed

Overview:
- Parametrised successor to the 1-bit serial comparators: compares two operands streamed as DIGIT_W-bit digits per beat.
- Framed by first/last markers with a valid qualifier.
- Bit order (MSB-first or LSB-first) and signedness are selectable per frame.
- Produces one registered result per frame, plus a per-frame beat-count guard and protocol-error reporting; used by serial datapaths that compare streamed keys or counters.

Parameters:
DIGIT_W, 1, bits of each operand delivered per beat (>=1).
MAX_BEATS, 16, maximum beats per frame (>=1); operand width = beats*DIGIT_W.
CNT_W, $clog2(MAX_BEATS+1), width of beat counter (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
in_valid  in  1  beat present this cycle; no backpressure, every valid beat is consumed.
in_first  in  1  beat is first of a frame (qualified by in_valid).
in_last  in  1  beat is last of a frame (qualified by in_valid); first&last = single-beat frame.
msb_first  in  1  frame order mode, sampled only on the first beat.
is_signed  in  1  two's-complement compare, sampled only on the first beat.
a  in  DIGIT_W  operand A digit.
b  in  DIGIT_W  operand B digit.
res_valid  out  1  one-cycle pulse: new result on res_* this cycle.
res_lt  out  1  A<B for last completed frame; held until next result.
res_eq  out  1  A==B, held.
res_gt  out  1  A>B, held.
res_beats  out  CNT_W  beat count of last completed frame, held.
busy  out  1  frame in progress (state != IDLE).
err  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset (rst=0, async): state IDLE, beat counter 0, mode regs 0, all outputs 0 (res_lt/eq/gt all 0 until first result).
- FSM states: IDLE, EQUAL, LESS, GREATER. busy=1 in EQUAL/LESS/GREATER.
- Digit compare per beat: dcmp = unsigned compare of a' vs b'.
  - a'=a, b'=b, except in the sign digit when signed: MSB of a and b inverted (offset-binary trick).
  - Sign digit = first beat if msb_first, last beat if LSB-first.
  - Sign and mode used: the sampled values on the first beat; live inputs on first beat itself.
- Next running relation (base = EQUAL on a first beat, else current state):
  - MSB-first: base EQUAL -> dcmp; base LESS/GREATER -> hold.
  - LSB-first: dcmp != EQ -> dcmp; dcmp == EQ -> hold base.
- Beat with in_first (any state): start frame; latch msb_first/is_signed; counter=1; state = next relation.
  - If a frame was already in progress (restart), err pulses next cycle; old frame discarded with no result.
- Beat without in_first in a frame: counter+1; state = next relation.
- Beat without in_first in IDLE: dropped, err pulses, state stays IDLE.
- Beat with in_last (frame in progress or starting): next cycle res_valid=1 with res_* = final relation, res_beats = counter incl. this beat; state -> IDLE.
  - Exactly one of res_lt/eq/gt is set after any result.
- Overflow: non-last beat that would make count exceed MAX_BEATS -> frame aborted, state IDLE, err pulses, no result.
  - A last beat at count MAX_BEATS is legal.
- in_valid=0: no state change; gaps between beats allowed, unlimited.
- Latency: result registered, 1 cycle after last beat. Back-to-back frames (last then first next cycle) sustained with no bubble.
- Reset mid-frame: abort immediately; no res_valid, no err.

Test Plan:
- DIGIT_W=1, MSB-first unsigned: A=0x6482, B=0x6262 over 16 beats -> res_valid one cycle after beat 16, res_gt=1, res_beats=16; busy=1 during frame.
- DIGIT_W=4, LSB-first unsigned: A=0x12, B=0x21 as beats (2,1),(1,2) -> res_lt=1. Same frame but A=B=0x5A -> res_eq=1.
- DIGIT_W=4, MSB-first, 2 beats: A=0xF0, B=0x10; is_signed=1 -> res_lt=1; repeat is_signed=0 -> res_gt=1. LSB-first signed with beats (0,0),(F,1) -> res_lt=1.
- MAX_BEATS=4, DIGIT_W=1: 5 beats, none marked last -> err pulse after beat 5, busy=0, no res_valid, previous res_* unchanged.
- Protocol: beat without first in IDLE -> err, no busy. in_first mid-frame -> err, new frame result only. Single-beat frame a=1, b=0 -> res_gt, res_beats=1. Back-to-back frames -> two res_valid pulses on consecutive result cycles.
- Async reset asserted mid-frame between clock edges -> outputs 0 immediately. After release, a fresh frame compares correctly.
